// File: rtl/rf_sweep_bypass.sv
// rf_sweep_bypass: parametrised multi-port register file with registered reads,
// write-to-read bypass and a hardware clear sweep after reset.
//
// Ports:
//   clk, rst         clock (rising edge) and asynchronous active-low reset
//   OUT_ready        1 once the post-reset clear sweep has finished
//   IN_readEnable    per-port read request
//   IN_readAddress   read port i address at [i*ADDR_W +: ADDR_W]
//   OUT_readValid    read data valid, one cycle after the request
//   OUT_readData     read port i data at [i*WIDTH +: WIDTH]
//   IN_writeEnable   per-port write request
//   IN_writeAddress  write port j address at [j*ADDR_W +: ADDR_W]
//   IN_writeData     write port j data at [j*WIDTH +: WIDTH]
//
// Address 0 and addresses >= SIZE are dead: writes are dropped and reads
// return 0 without bypass. Among write ports, the highest index wins.

// Per-read-port output stage: selects bypass/array data and registers it.
module rf_sweep_bypass_rport #(
  parameter int NUM_WRITE = 3,
  parameter int WIDTH     = 32,
  parameter int ADDR_W    = 6
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                i_en,     // already qualified by RUN
  input  logic [ADDR_W-1:0]                   i_addr,
  input  logic                                i_live,   // address is a real entry
  input  logic [WIDTH-1:0]                    i_mem_q,  // array word at i_addr
  input  logic [NUM_WRITE-1:0]                i_wlive,  // write ports committing this edge
  input  logic [NUM_WRITE-1:0][ADDR_W-1:0]    i_wa,
  input  logic [NUM_WRITE-1:0][WIDTH-1:0]     i_wd,
  output logic                                o_valid,
  output logic [WIDTH-1:0]                    o_data
);
  logic [WIDTH-1:0] w_data;

  // Ascending scan so the highest matching write port is the one that sticks.
  always_comb begin
    w_data = i_live ? i_mem_q : '0;
    for (int j = 0; j < NUM_WRITE; j++)
      if (i_live && i_wlive[j] && (i_wa[j] == i_addr)) w_data = i_wd[j];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      o_valid <= 1'b0;
      o_data  <= '0;
    end else begin
      o_valid <= i_en;
      if (i_en) o_data <= w_data;   // data holds when no request
    end
  end
endmodule

module rf_sweep_bypass #(
  parameter int NUM_READ  = 4,
  parameter int NUM_WRITE = 3,
  parameter int SIZE      = 64,
  parameter int WIDTH     = 32,
  parameter int ADDR_W    = 6
) (
  input  logic                          clk,
  input  logic                          rst,
  output logic                          OUT_ready,
  input  logic [NUM_READ-1:0]           IN_readEnable,
  input  logic [NUM_READ*ADDR_W-1:0]    IN_readAddress,
  output logic [NUM_READ-1:0]           OUT_readValid,
  output logic [NUM_READ*WIDTH-1:0]     OUT_readData,
  input  logic [NUM_WRITE-1:0]          IN_writeEnable,
  input  logic [NUM_WRITE*ADDR_W-1:0]   IN_writeAddress,
  input  logic [NUM_WRITE*WIDTH-1:0]    IN_writeData
);
  typedef enum logic {S_CLEAR, S_RUN} state_t;

  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(SIZE - 1);

  state_t                              r_state, w_state_nxt;
  logic [ADDR_W-1:0]                   r_ptr, w_ptr_nxt;
  logic                                w_run;

  logic [NUM_READ-1:0][ADDR_W-1:0]     w_ra;
  logic [NUM_WRITE-1:0][ADDR_W-1:0]    w_wa;
  logic [NUM_WRITE-1:0][WIDTH-1:0]     w_wd;
  logic [NUM_WRITE-1:0]                w_wlive;
  logic [NUM_READ-1:0]                 w_rlive;
  logic [NUM_READ-1:0][WIDTH-1:0]      w_rq;
  logic [NUM_READ-1:0][WIDTH-1:0]      w_rd;

  // Sized to the full address space so every address indexes exactly;
  // entries >= SIZE are never written and their reads are masked, so they
  // carry no logic.
  logic [WIDTH-1:0] r_mem [2**ADDR_W];

  function automatic logic f_live(input logic [ADDR_W-1:0] a);
    return (a != '0) && ({{(32-ADDR_W){1'b0}}, a} < 32'(SIZE));
  endfunction

  assign w_ra = IN_readAddress;
  assign w_wa = IN_writeAddress;
  assign w_wd = IN_writeData;

  // ---- clear-sweep FSM ----
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_CLEAR;
      r_ptr   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_ptr   <= w_ptr_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_ptr_nxt   = r_ptr;
    case (r_state)
      S_CLEAR: begin
        if (r_ptr == LAST) w_state_nxt = S_RUN;
        else               w_ptr_nxt   = r_ptr + 1'b1;
      end
      default: ;   // RUN is terminal until reset
    endcase
  end

  assign w_run     = (r_state == S_RUN);
  assign OUT_ready = w_run;

  always_comb
    for (int j = 0; j < NUM_WRITE; j++)
      w_wlive[j] = w_run && IN_writeEnable[j] && f_live(w_wa[j]);

  // ---- array: sweep clears one entry per cycle, then ports write ----
  always_ff @(posedge clk) begin
    if (!w_run) r_mem[r_ptr] <= '0;
    else
      for (int j = 0; j < NUM_WRITE; j++)
        if (w_wlive[j]) r_mem[w_wa[j]] <= w_wd[j];
  end

  // ---- read ports ----
  for (genvar i = 0; i < NUM_READ; i++) begin : g_rp
    assign w_rlive[i] = f_live(w_ra[i]);
    assign w_rq[i]    = r_mem[w_ra[i]];

    rf_sweep_bypass_rport #(
      .NUM_WRITE (NUM_WRITE),
      .WIDTH     (WIDTH),
      .ADDR_W    (ADDR_W)
    ) u_rp (
      .clk     (clk),
      .rst     (rst),
      .i_en    (w_run && IN_readEnable[i]),
      .i_addr  (w_ra[i]),
      .i_live  (w_rlive[i]),
      .i_mem_q (w_rq[i]),
      .i_wlive (w_wlive),
      .i_wa    (w_wa),
      .i_wd    (w_wd),
      .o_valid (OUT_readValid[i]),
      .o_data  (w_rd[i])
    );
  end

  assign OUT_readData = w_rd;
endmodule

// File: tb/tb_rf_sweep_bypass.sv
// Bench for rf_sweep_bypass: two instances (SIZE=64 and SIZE=40) driven by
// directed steps and random traffic, checked against a behavioural model.
module tb_rf_sweep_bypass;
  localparam int NR = 4, NW = 3, AW = 6, W = 32;

  int sz [2] = '{64, 40};

  logic clk = 1'b0;
  logic rst = 1'b0;

  logic [NR-1:0] re [2];
  logic [AW-1:0] ra [2][NR];
  logic [NW-1:0] we [2];
  logic [AW-1:0] wa [2][NW];
  logic [W-1:0]  wd [2][NW];

  logic [NR*AW-1:0] ra_f [2];
  logic [NW*AW-1:0] wa_f [2];
  logic [NW*W-1:0]  wd_f [2];

  logic          rdy [2];
  logic [NR-1:0] vld [2];
  logic [NR*W-1:0] rd [2];

  // model state
  logic [W-1:0]  m_mem [2][64];
  int            m_cnt [2];
  logic [NR-1:0] e_vld [2];
  logic [W-1:0]  e_dat [2][NR];

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  always_comb begin
    for (int d = 0; d < 2; d++) begin
      ra_f[d] = '0;
      wa_f[d] = '0;
      wd_f[d] = '0;
      for (int i = 0; i < NR; i++) ra_f[d][i*AW +: AW] = ra[d][i];
      for (int j = 0; j < NW; j++) begin
        wa_f[d][j*AW +: AW] = wa[d][j];
        wd_f[d][j*W +: W]   = wd[d][j];
      end
    end
  end

  rf_sweep_bypass #(.NUM_READ(NR), .NUM_WRITE(NW), .SIZE(64), .WIDTH(W), .ADDR_W(AW)) u_a (
    .clk(clk), .rst(rst), .OUT_ready(rdy[0]),
    .IN_readEnable(re[0]), .IN_readAddress(ra_f[0]),
    .OUT_readValid(vld[0]), .OUT_readData(rd[0]),
    .IN_writeEnable(we[0]), .IN_writeAddress(wa_f[0]), .IN_writeData(wd_f[0]));

  rf_sweep_bypass #(.NUM_READ(NR), .NUM_WRITE(NW), .SIZE(40), .WIDTH(W), .ADDR_W(AW)) u_b (
    .clk(clk), .rst(rst), .OUT_ready(rdy[1]),
    .IN_readEnable(re[1]), .IN_readAddress(ra_f[1]),
    .OUT_readValid(vld[1]), .OUT_readData(rd[1]),
    .IN_writeEnable(we[1]), .IN_writeAddress(wa_f[1]), .IN_writeData(wd_f[1]));

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic clr_in();
    for (int d = 0; d < 2; d++) begin
      re[d] = '0;
      we[d] = '0;
      for (int i = 0; i < NR; i++) ra[d][i] = '0;
      for (int j = 0; j < NW; j++) begin wa[d][j] = '0; wd[d][j] = '0; end
    end
  endtask

  // Reset brings outputs to 0; contents read as 0 once the sweep completes.
  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      m_cnt[d] = 0;
      e_vld[d] = '0;
      for (int i = 0; i < NR; i++) e_dat[d][i] = '0;
      for (int k = 0; k < 64; k++) m_mem[d][k] = '0;
    end
  endtask

  task automatic check_all(input string tag);
    for (int d = 0; d < 2; d++) begin
      check($sformatf("%s.ready%0d", tag, d), {31'b0, rdy[d]}, {31'b0, m_cnt[d] >= sz[d]});
      for (int i = 0; i < NR; i++) begin
        check($sformatf("%s.vld%0d.%0d", tag, d, i), {31'b0, vld[d][i]}, {31'b0, e_vld[d][i]});
        check($sformatf("%s.dat%0d.%0d", tag, d, i), rd[d][i*W +: W], e_dat[d][i]);
      end
    end
  endtask

  // One clock: evaluate the model on the current inputs, clock, then compare.
  task automatic tick(input string tag);
    logic [W-1:0] v;
    int a;
    if (rst) begin
      for (int d = 0; d < 2; d++) begin
        if (m_cnt[d] >= sz[d]) begin
          for (int i = 0; i < NR; i++) begin
            if (re[d][i]) begin
              a = int'(ra[d][i]);
              v = '0;
              if (a != 0 && a < sz[d]) begin
                v = m_mem[d][a];
                for (int j = 0; j < NW; j++)
                  if (we[d][j] && int'(wa[d][j]) == a) v = wd[d][j];
              end
              e_vld[d][i] = 1'b1;
              e_dat[d][i] = v;
            end else e_vld[d][i] = 1'b0;
          end
          for (int j = 0; j < NW; j++) begin
            a = int'(wa[d][j]);
            if (we[d][j] && a != 0 && a < sz[d]) m_mem[d][a] = wd[d][j];
          end
        end else begin
          e_vld[d] = '0;
          m_cnt[d]++;
        end
      end
    end
    @(posedge clk);
    #1;
    check_all(tag);
  endtask

  initial begin
    clr_in();
    model_reset();
    rst = 1'b0;
    tick("rst");
    tick("rst");
    rst = 1'b1;

    // T1: sweep length, then every address reads 0
    for (int k = 0; k < 64; k++) tick("sweep");
    check("T1.ready", {31'b0, rdy[0]}, 32'd1);
    for (int k = 0; k < 16; k++) begin
      clr_in();
      for (int i = 0; i < NR; i++) begin re[0][i] = 1'b1; ra[0][i] = AW'(4*k + i); end
      tick("T1.read");
    end

    // T2: write then read
    clr_in();
    we[0][0] = 1'b1; wa[0][0] = 6'd5; wd[0][0] = 32'hDEADBEEF;
    tick("T2.w");
    clr_in();
    re[0][3] = 1'b1; ra[0][3] = 6'd5;
    tick("T2.r");
    check("T2.valid", {31'b0, vld[0][3]}, 32'd1);
    check("T2.data", rd[0][3*W +: W], 32'hDEADBEEF);

    // T3: same-cycle conflict + bypass
    clr_in();
    we[0][0] = 1'b1; wa[0][0] = 6'd9; wd[0][0] = 32'h11;
    we[0][2] = 1'b1; wa[0][2] = 6'd9; wd[0][2] = 32'h22;
    re[0][1] = 1'b1; ra[0][1] = 6'd9;
    tick("T3.byp");
    check("T3.bypass", rd[0][1*W +: W], 32'h22);
    clr_in();
    re[0][2] = 1'b1; ra[0][2] = 6'd9;
    tick("T3.r");
    check("T3.stored", rd[0][2*W +: W], 32'h22);

    // T4: addr 0 and out-of-range on SIZE=40
    clr_in();
    we[1][0] = 1'b1; wa[1][0] = 6'd0;  wd[1][0] = 32'hFF;
    we[1][1] = 1'b1; wa[1][1] = 6'd45; wd[1][1] = 32'hFF;
    re[1][0] = 1'b1; ra[1][0] = 6'd0;
    re[1][1] = 1'b1; ra[1][1] = 6'd45;
    tick("T4.byp");
    check("T4.addr0", rd[1][0 +: W], 32'h0);
    check("T4.addr45", rd[1][W +: W], 32'h0);
    clr_in();
    re[1][2] = 1'b1; ra[1][2] = 6'd0;
    tick("T4.r");
    check("T4.addr0.later", rd[1][2*W +: W], 32'h0);

    // T6: hold last data while idle
    clr_in();
    we[0][1] = 1'b1; wa[0][1] = 6'd3; wd[0][1] = 32'h77;
    tick("T6.w");
    clr_in();
    re[0][0] = 1'b1; ra[0][0] = 6'd3;
    tick("T6.r");
    check("T6.data", rd[0][0 +: W], 32'h77);
    clr_in();
    for (int k = 0; k < 3; k++) begin
      tick("T6.idle");
      check("T6.hold.valid", {31'b0, vld[0][0]}, 32'd0);
      check("T6.hold.data", rd[0][0 +: W], 32'h77);
    end

    // random traffic, addresses biased low to force conflicts and bypasses
    for (int k = 0; k < 400; k++) begin
      for (int d = 0; d < 2; d++) begin
        re[d] = NR'($urandom);
        we[d] = NW'($urandom);
        for (int i = 0; i < NR; i++)
          ra[d][i] = ($urandom_range(0, 3) == 0) ? AW'($urandom) : AW'($urandom_range(0, 12));
        for (int j = 0; j < NW; j++) begin
          wa[d][j] = ($urandom_range(0, 3) == 0) ? AW'($urandom) : AW'($urandom_range(0, 12));
          wd[d][j] = $urandom;
        end
      end
      tick("rand");
    end

    // T5: write, reset, abort the next sweep at ptr 20, full sweep redone
    clr_in();
    we[0][0] = 1'b1; wa[0][0] = 6'd7; wd[0][0] = 32'h5A;
    tick("T5.w");
    clr_in();
    rst = 1'b0;
    model_reset();
    #2;
    rst = 1'b1;
    for (int k = 0; k < 20; k++) begin
      re[0] = '1;       // requests during the sweep are discarded
      tick("T5.sweep1");
    end
    rst = 1'b0;
    model_reset();
    #2;
    check_all("T5.abort");
    check("T5.ready0", {31'b0, rdy[0]}, 32'd0);
    rst = 1'b1;
    clr_in();
    for (int k = 0; k < 63; k++) tick("T5.sweep2");
    check("T5.notready", {31'b0, rdy[0]}, 32'd0);
    tick("T5.sweep2.end");
    check("T5.ready1", {31'b0, rdy[0]}, 32'd1);
    re[0][0] = 1'b1; ra[0][0] = 6'd7;
    tick("T5.r");
    check("T5.addr7", rd[0][0 +: W], 32'h0);
    check("T5.valid", {31'b0, vld[0][0]}, 32'd1);

    clr_in();
    tick("end");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
